// File: rtl/osd_char_overlay_if.sv
// ROM read bus between the overlay reader and the OSD font/bitmap ROM.
// The ROM registers the address and returns data one cycle later.
interface osd_char_overlay_if #(
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [7:0]            rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/osd_char_overlay.sv
// Inline OSD overlay: tracks pixel/line position, reads a 1bpp bitmap from ROM and
// paints set bits inside a fixed window with OSD_COLOR. Fixed two-cycle latency.
module osd_char_overlay #(
    parameter int unsigned OSD_X      = 100,
    parameter int unsigned OSD_Y      = 100,
    parameter int unsigned OSD_W      = 256,
    parameter int unsigned OSD_H      = 64,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter logic [23:0] OSD_COLOR  = 24'hFF0000,
    parameter bit          VS_POL     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      osd_en,
    input  logic                      i_hs,
    input  logic                      i_vs,
    input  logic                      i_de,
    input  logic [23:0]               i_data,
    osd_char_overlay_if.master        rom_if,
    output logic                      o_hs,
    output logic                      o_vs,
    output logic                      o_de,
    output logic [23:0]               o_data
);

    localparam logic [12:0] XLo  = 13'(OSD_X);
    localparam logic [12:0] XHi  = 13'(OSD_X + OSD_W);
    localparam logic [12:0] YLo  = 13'(OSD_Y);
    localparam logic [12:0] YHi  = 13'(OSD_Y + OSD_H);
    localparam logic [11:0] XOff = 12'(OSD_X);
    localparam logic [11:0] YOff = 12'(OSD_Y);
    localparam logic [ADDR_WIDTH-1:0] BytesPerLine = ADDR_WIDTH'(OSD_W / 8);

    logic [11:0] r_x_cnt;
    logic [11:0] r_y_cnt;
    logic        r_en_frame;
    logic        r_hs_d1;
    logic        r_vs_d1;
    logic        r_de_d1;
    logic [23:0] r_data_d1;
    logic        r_in_win_d1;
    logic [2:0]  r_bit_idx_d1;

    logic                  w_vs_edge;
    logic                  w_de_fall;
    logic [11:0]           w_x_rel;
    logic [11:0]           w_y_rel;
    logic                  w_in_win;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_bit;

    // r_vs_d1 doubles as the previous-cycle vsync for edge detection.
    assign w_vs_edge = (i_vs == VS_POL) && (r_vs_d1 != VS_POL);
    assign w_de_fall = r_de_d1 & ~i_de;

    assign w_x_rel = r_x_cnt - XOff;
    assign w_y_rel = r_y_cnt - YOff;

    always_comb begin
        w_in_win = i_de & r_en_frame
                 & ({1'b0, r_x_cnt} >= XLo) & ({1'b0, r_x_cnt} < XHi)
                 & ({1'b0, r_y_cnt} >= YLo) & ({1'b0, r_y_cnt} < YHi);
        w_addr   = ADDR_WIDTH'(w_y_rel) * BytesPerLine + ADDR_WIDTH'(w_x_rel >> 3);
        rom_if.rom_addr = w_in_win ? w_addr : '0;
    end

    // Bit 7 of each bitmap byte is the leftmost pixel, so index with ~bit_idx.
    assign w_bit = rom_if.rom_data[~r_bit_idx_d1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_en_frame <= 1'b0;
        end else begin
            if (!i_de) begin
                r_x_cnt <= '0;
            end else if (r_x_cnt != 12'hFFF) begin
                r_x_cnt <= r_x_cnt + 12'd1;
            end

            if (w_vs_edge) begin
                r_y_cnt <= '0;
            end else if (w_de_fall && (r_y_cnt != 12'hFFF)) begin
                r_y_cnt <= r_y_cnt + 12'd1;
            end

            if (w_vs_edge) begin
                r_en_frame <= osd_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_d1      <= 1'b0;
            r_vs_d1      <= 1'b0;
            r_de_d1      <= 1'b0;
            r_data_d1    <= '0;
            r_in_win_d1  <= 1'b0;
            r_bit_idx_d1 <= '0;
            o_hs         <= 1'b0;
            o_vs         <= 1'b0;
            o_de         <= 1'b0;
            o_data       <= '0;
        end else begin
            r_hs_d1      <= i_hs;
            r_vs_d1      <= i_vs;
            r_de_d1      <= i_de;
            r_data_d1    <= i_data;
            r_in_win_d1  <= w_in_win;
            r_bit_idx_d1 <= w_x_rel[2:0];
            o_hs         <= r_hs_d1;
            o_vs         <= r_vs_d1;
            o_de         <= r_de_d1;
            o_data       <= (r_in_win_d1 & w_bit) ? OSD_COLOR : r_data_d1;
        end
    end

endmodule

// File: tb/tb_osd_char_overlay.sv
// Randomized bench for osd_char_overlay with a position/window reference model
// and a handful of literal expectations taken from hand-worked pixel positions.
module tb_osd_char_overlay;

    localparam int          X0    = 4;
    localparam int          Y0    = 2;
    localparam int          W     = 16;
    localparam int          H     = 4;
    localparam logic [23:0] COLOR = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        osd_en;
    logic        i_hs;
    logic        i_vs;
    logic        i_de;
    logic [23:0] i_data;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [23:0] o_data;

    osd_char_overlay_if #(.ADDR_WIDTH(11)) rom_bus ();

    osd_char_overlay #(
        .OSD_X(4), .OSD_Y(2), .OSD_W(16), .OSD_H(4), .ADDR_WIDTH(11),
        .OSD_COLOR(24'hFF0000), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .osd_en(osd_en), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .i_data(i_data), .rom_if(rom_bus.master), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
        .o_data(o_data)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:2047];
    always @(posedge clk) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc_n, act, exp);
        end
    endtask

    typedef struct { int unsigned cyc; logic de; logic [23:0] data; } lit_t;
    lit_t lit_q[$];

    // Reference model: position, frame enable and two-deep expected output pipe.
    int         m_x = 0, m_y = 0;
    bit         m_en = 0, m_pv = 0, m_pd = 0, m_valid = 0;
    logic [26:0] s1 = '0, s2 = '0;

    always @(negedge clk) begin : model_p
        int xr, yr, ea;
        bit win;
        logic [23:0] d;
        win = i_de && m_en && m_x >= X0 && m_x < X0 + W && m_y >= Y0 && m_y < Y0 + H;
        xr  = m_x - X0;
        yr  = m_y - Y0;
        ea  = win ? yr * (W / 8) + xr / 8 : 0;
        if (m_valid) begin
            chk("rom_addr", 32'(rom_bus.rom_addr), 32'(ea));
            chk("outputs", {5'b0, o_hs, o_vs, o_de, o_data}, {5'b0, s2});
            while (lit_q.size() > 0 && lit_q[0].cyc <= cyc_n) begin
                chk("literal_o_de", 32'(o_de), 32'(lit_q[0].de));
                chk("literal_o_data", 32'(o_data), 32'(lit_q[0].data));
                void'(lit_q.pop_front());
            end
        end
        d = i_data;
        if (win) begin
            if (rom_mem[ea][7 - (xr % 8)]) d = COLOR;
        end
        if (rst === 1'b1) begin
            m_valid = 1; m_x = 0; m_y = 0; m_en = 0; m_pv = 0; m_pd = 0;
            s1 = '0; s2 = '0;
        end else begin
            s2 = s1;
            s1 = {i_hs, i_vs, i_de, d};
            if (i_vs && !m_pv) begin
                m_y  = 0;
                m_en = osd_en;
            end else if (m_pd && !i_de && m_y < 4095) begin
                m_y = m_y + 1;
            end
            m_x  = i_de ? ((m_x < 4095) ? m_x + 1 : 4095) : 0;
            m_pv = i_vs;
            m_pd = i_de;
        end
    end

    logic        en_req = 1'b0;
    bit          lit_mask [64];
    logic [23:0] lit_val  [64];

    task automatic cyc(input bit r, input bit h, input bit v, input bit d,
                       input logic [23:0] dat);
        @(posedge clk);
        #1;
        rst = r; i_hs = h; i_vs = v; i_de = d; i_data = dat; osd_en = en_req;
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 24'($urandom));
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 24'($urandom));
    endtask

    task automatic line(input int pix, input bit use_lit, input bit fixed,
                        input logic [23:0] fdat, input int chk_x, input int chk_a);
        int nb;
        nb = $urandom_range(2, 5);
        for (int b = 0; b < nb; b++) cyc(0, b == 0, 0, 0, 24'($urandom));
        for (int x = 0; x < pix; x++) begin
            cyc(0, 0, 0, 1, fixed ? fdat : 24'($urandom));
            if (use_lit && x < 64 && lit_mask[x])
                lit_q.push_back('{cyc: cyc_n + 2, de: 1'b1, data: lit_val[x]});
            if (x == chk_x) begin
                #1;
                chk("literal_rom_addr", 32'(rom_bus.rom_addr), 32'(chk_a));
            end
        end
    endtask

    task automatic frame(input int lines, input int pix, input int lit_line, input bit fixed,
                         input logic [23:0] fdat, input int chk_y, input int chk_x,
                         input int chk_a, input int tog_line, input bit tog_val);
        vs_pulse();
        for (int l = 0; l < lines; l++) begin
            if (l == tog_line) en_req = tog_val;
            line(pix, l == lit_line, fixed && l == lit_line, fdat,
                 (l == chk_y) ? chk_x : -1, chk_a);
        end
    endtask

    task automatic clear_lit();
        for (int i = 0; i < 64; i++) begin
            lit_mask[i] = 0;
            lit_val[i]  = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = 8'b1000_0001;
        rom_mem[1] = 8'h00;
        clear_lit();
        rst = 1; osd_en = 0; i_hs = 0; i_vs = 0; i_de = 0; i_data = '0;

        // Reset with random video activity, then release with DE low.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
            if (i == 0) lit_q.push_back('{cyc: cyc_n + 1, de: 1'b0, data: 24'h0});
        end
        for (int i = 0; i < 4; i++) cyc(0, 1'($urandom), 1'($urandom), 0, 24'($urandom));

        // Pass-through with overlay disabled.
        en_req = 0;
        lit_mask[4] = 1; lit_val[4] = 24'h123456;
        frame(6, 32, 2, 1, 24'h123456, 2, 12, 0, -1, 0);
        clear_lit();

        // Addressing.
        en_req = 1;
        frame(6, 32, -1, 0, 0, 3, 12, 3, -1, 0);
        frame(6, 32, -1, 0, 0, 5, 19, 7, -1, 0);
        frame(6, 32, -1, 0, 0, 2, 3, 0, -1, 0);
        frame(6, 32, -1, 0, 0, 2, 20, 0, -1, 0);

        // Overlay bits: ROM[0]=0x81 lights x=4 and x=11, ROM[1]=0 lights nothing.
        for (int x = 4; x < 20; x++) begin
            lit_mask[x] = 1;
            lit_val[x]  = (x == 4 || x == 11) ? COLOR : 24'h00FF00;
        end
        frame(6, 32, 2, 1, 24'h00FF00, -1, -1, 0, -1, 0);
        clear_lit();

        // Enable is latched per frame.
        en_req = 1;
        frame(6, 32, -1, 0, 0, 3, 12, 3, 1, 0);
        frame(6, 32, -1, 0, 0, 3, 12, 0, 0, 1);
        frame(6, 32, -1, 0, 0, 3, 12, 3, -1, 0);

        // Very long line: x must saturate rather than wrap back into the window.
        vs_pulse();
        line(32, 0, 0, 0, -1, 0);
        line(32, 0, 0, 0, -1, 0);
        line(4200, 0, 0, 0, 4100, 0);
        line(32, 0, 0, 0, 12, 3);

        // Mid-frame reset at line 3, x=8.
        vs_pulse();
        for (int l = 0; l < 3; l++) line(32, 0, 0, 0, -1, 0);
        for (int b = 0; b < 3; b++) cyc(0, 0, 0, 0, 24'($urandom));
        for (int x = 0; x < 8; x++) cyc(0, 0, 0, 1, 24'($urandom));
        cyc(1, 1, 1, 1, 24'hABCDEF);
        lit_q.push_back('{cyc: cyc_n + 1, de: 1'b0, data: 24'h0});
        cyc(1, 0, 0, 1, 24'($urandom));
        for (int b = 0; b < 3; b++) cyc(0, 0, 0, 0, 24'($urandom));
        for (int x = 0; x < 20; x++) cyc(0, 0, 0, 1, 24'($urandom));
        // DE falls in the same cycle VS rises.
        cyc(0, 0, 1, 0, 24'($urandom));
        cyc(0, 0, 1, 0, 24'($urandom));
        for (int b = 0; b < 2; b++) cyc(0, 0, 0, 0, 24'($urandom));
        line(32, 0, 0, 0, 12, 0);
        line(32, 0, 0, 0, 12, 0);
        line(32, 0, 0, 0, 12, 1);
        line(32, 0, 0, 0, 12, 3);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            en_req = 1'($urandom);
            frame($urandom_range(6, 8), $urandom_range(16, 40), -1, 0, 0, -1, -1, 0,
                  int'($urandom_range(0, 8)) - 1, 1'($urandom));
        end

        // Unstructured random bits, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            en_req = 1'($urandom);
            cyc(($urandom % 64) == 0, 1'($urandom), ($urandom % 8) == 0, ($urandom % 4) != 0,
                24'($urandom));
        end

        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 24'h0);
        chk("literal_queue_drained", 32'(lit_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
